// File: rtl/ibus_responder_if.sv
// Instruction fetch bus between a core fetch unit (master) and the responder (slave).
// Carries the request, the response and the fetch error pulse.
interface ibus_responder_if;
  typedef struct packed {
    logic        valid;
    logic [63:0] addr;
  } ibus_req_t;

  typedef struct packed {
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] data;
  } ibus_resp_t;

  ibus_req_t  ireq;
  ibus_resp_t iresp;
  logic       fetch_err;

  modport master (output ireq, input  iresp, input  fetch_err);
  modport slave  (input  ireq, output iresp, output fetch_err);
endinterface

// File: rtl/ibus_responder.sv
// Fixed-latency instruction memory responder: one fetch in flight, NOP plus error pulse on bad addresses.
// state | meaning
// IDLE  | waiting for ireq.valid; addr_ok is combinational on accept
// BUSY  | wait counter running down to the read sample
// RESP  | data_ok (and fetch_err on a bad address) for one cycle
module ibus_responder #(
  parameter int          MEM_WORDS = 1024,
  parameter int          LATENCY   = 2,
  parameter logic [63:0] BASE_ADDR = 64'h8000_0000
) (
  input  logic        clk,
  input  logic        rst,
  ibus_responder_if.slave ibus,
  input  logic        wr_en,
  input  logic [63:0] wr_addr,
  input  logic [31:0] wr_data
);

  localparam int          AW     = $clog2(MEM_WORDS);
  localparam logic [3:0]  LAT_M1 = 4'(LATENCY - 1);
  localparam logic [31:0] NOP    = 32'h0000_0013;

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_RESP} state_t;

  state_t      state, state_nx;
  logic [3:0]  cnt;
  logic [63:0] addr_q;
  logic [31:0] data_q;
  logic        err_q;
  logic        accept;
  logic        sample;
  logic [63:0] rd_addr;
  logic        rd_hit;
  logic [AW-1:0] rd_idx;
  logic        wr_hit;
  logic [AW-1:0] wr_idx;

  logic [31:0] mem [MEM_WORDS];

  // Addresses below BASE_ADDR wrap to huge offsets and fail the range compare.
  function automatic logic addr_hit(input logic [63:0] a);
    logic [63:0] off;
    off = a - BASE_ADDR;
    return (a[1:0] == 2'b00) && ((off >> 2) < 64'(MEM_WORDS));
  endfunction

  function automatic logic [AW-1:0] word_idx(input logic [63:0] a);
    logic [63:0] off;
    off = a - BASE_ADDR;
    return off[AW+1:2];
  endfunction

  assign rd_hit = addr_hit(rd_addr);
  assign rd_idx = word_idx(rd_addr);
  assign wr_hit = addr_hit(wr_addr);
  assign wr_idx = word_idx(wr_addr);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    accept   = 1'b0;
    sample   = 1'b0;
    rd_addr  = addr_q;
    case (state)
      S_IDLE: begin
        // With LATENCY=1 the read sample coincides with the accept edge.
        rd_addr = ibus.ireq.addr;
        if (ibus.ireq.valid && rst) begin
          accept = 1'b1;
          if (LATENCY == 1) begin
            sample   = 1'b1;
            state_nx = S_RESP;
          end else begin
            state_nx = S_BUSY;
          end
        end
      end
      S_BUSY: begin
        if (cnt == 4'd1) begin
          sample   = 1'b1;
          state_nx = S_RESP;
        end
      end
      S_RESP:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt    <= '0;
      addr_q <= '0;
      data_q <= '0;
      err_q  <= 1'b0;
    end else begin
      if (accept) begin
        addr_q <= ibus.ireq.addr;
        cnt    <= LAT_M1;
      end else if (state == S_BUSY) begin
        cnt <= cnt - 4'd1;
      end
      if (sample) begin
        data_q <= rd_hit ? mem[rd_idx] : NOP;
        err_q  <= !rd_hit;
      end
    end
  end

  // Preload port; the array is deliberately outside the reset domain.
  always_ff @(posedge clk) begin
    if (wr_en && wr_hit) mem[wr_idx] <= wr_data;
  end

  assign ibus.iresp     = {accept, (state == S_RESP), data_q};
  assign ibus.fetch_err = (state == S_RESP) && err_q;

endmodule

// File: doc/ibus_responder.md
IBUS_RESPONDER -- requirements
Module: ibus_responder

Interface
REQ-001 The block SHALL have parameter MEM_WORDS, default 1024, giving the instruction memory depth in 32-bit words (power of two).
REQ-002 The block SHALL have parameter LATENCY, default 2, giving the cycles from request accept to data_ok (legal range 1..15).
REQ-003 The block SHALL have parameter BASE_ADDR, default 64'h8000_0000, giving the byte address of word 0.
REQ-004 Port clk  input  1  is the single clock; all state changes on its rising edge.
REQ-005 Port rst  input  1  is the asynchronous, active-low reset.
REQ-006 Port ireq  input  ibus_req_t  is the fetch request; fields used are valid (1) and addr (64).
REQ-007 Port iresp  output  ibus_resp_t  is the fetch response; fields driven are addr_ok (1), data_ok (1) and data (32).
REQ-008 Port wr_en  input  1  is the memory preload write strobe.
REQ-009 Port wr_addr  input  64  is the preload byte address.
REQ-010 Port wr_data  input  32  is the preload write data.
REQ-011 Port fetch_err  output  1  is a one-cycle pulse, concurrent with data_ok, flagging a misaligned or out-of-range fetch.

Function
REQ-012 The block SHALL implement a three-state FSM: IDLE, BUSY and RESP.
REQ-013 In IDLE with ireq.valid=1, the block SHALL latch ireq.addr, assert iresp.addr_ok for exactly that cycle, load the wait counter with LATENCY-1, and go to BUSY; when LATENCY=1 it SHALL go directly to RESP.
REQ-014 In BUSY, the counter SHALL decrement each cycle; when it reaches 0 the memory word SHALL be read into the data register and the FSM SHALL go to RESP on the next edge.
REQ-015 In RESP, iresp.data_ok SHALL be 1 for exactly one cycle with iresp.data valid; the FSM SHALL then return to IDLE.
REQ-016 data_ok SHALL rise exactly LATENCY cycles after the addr_ok cycle, giving one accept per LATENCY+1 cycles at most.
REQ-017 Requests SHALL be accepted only in IDLE; ireq.valid in BUSY or RESP SHALL be ignored (no queueing).
REQ-018 A request with ireq.valid deasserted after accept SHALL still complete; no cancellation.
REQ-019 The word index SHALL be (addr - BASE_ADDR) >> 2, computed in 64-bit unsigned arithmetic.
REQ-020 If addr[1:0] != 0, or the index is >= MEM_WORDS (including addr < BASE_ADDR through wrap-around), the response SHALL carry data 32'h0000_0013 (NOP) with fetch_err=1.
REQ-021 A write with wr_en=1 and an in-range, aligned wr_addr SHALL update the word on the clock edge; any other write SHALL be dropped silently.
REQ-022 A write to the word being read in the same cycle as the read sample (REQ-014) SHALL NOT affect that response; the old data is returned.
REQ-023 A write in the cycles before the read sample SHALL be visible in the response.
REQ-024 iresp.data SHALL hold its last value outside RESP; addr_ok, data_ok and fetch_err SHALL be 0 outside their defined cycles.

Reset
REQ-025 On rst=0 the block SHALL immediately force the FSM to IDLE, the counter to 0, addr_ok, data_ok and fetch_err to 0, and iresp.data to 0, regardless of clock.
REQ-026 Reset mid-transaction SHALL discard the pending request; no data_ok SHALL follow after release.
REQ-027 Memory contents SHALL NOT be cleared by reset.
REQ-028 The first request SHALL be accepted on the first rising edge with rst=1 and ireq.valid=1.

Verification
REQ-029 Preload word 0 = 32'h0010_0093, LATENCY=2, fetch 64'h8000_0000 -> addr_ok in cycle 0, data_ok with data 32'h0010_0093 in cycle 2, fetch_err=0.
REQ-030 ireq.valid held high with addr advancing by 4 on each data_ok -> one data_ok every 3 cycles with sequential words and no duplicates.
REQ-031 Fetch 64'h8000_0002 -> data 32'h0000_0013, fetch_err=1. Fetch 64'h7FFF_FFFC -> same response. Fetch BASE_ADDR+4*MEM_WORDS -> same response.
REQ-032 Write word 5 during BUSY of a fetch to word 5, before the read sample -> new value returned. Write in the sample cycle -> old value returned.
REQ-033 Assert rst=0 in BUSY, then release -> no data_ok appears. The next request completes normally with LATENCY timing.
REQ-034 LATENCY=1 -> data_ok is asserted in the cycle immediately after addr_ok.
